multicycle_control_unit: RTL
============================

# multicycle_control_unit

- Multi-cycle control FSM for the RISC-V integer core; replaces the single-cycle combinational decoder.
- Latches each instruction at fetch and sequences it through DECODE / EXECUTE / MEM / WB.
- Handshakes with instruction and data memory, with a parametrised wait timeout.
- Evaluates all six RV32I branch conditions, flags illegal encodings and counts retired instructions.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles on imem/dmem before a bus-error trap; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports (clock/reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- ins_code  in  32  instruction word from imem; sampled when imem_req && imem_ready
- imem_ready  in  1  imem holds valid ins_code
- dmem_ready  in  1  data access complete
- alu_zero, alu_lt, alu_ltu  in  1 each  comparator flags from ALU (rs1 vs rs2)
- imem_req  out  1  fetch request
- dmem_req  out  1  data access request
- mem_read, mem_write  out  1 each  data access direction, valid with dmem_req
- ir_write  out  1  datapath captures instruction / operands
- pc_write  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = ALU result
- alu_a_sel  out  2  0 = rs1, 1 = old PC, 2 = zero
- alusrc  out  1  0 = rs2, 1 = immediate
- alu_ctrl  out  4  ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001
- regwrite  out  1  register file write strobe
- writeback_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4
- trap  out  1  sticky fault flag
- trap_cause  out  2  1 = illegal instruction, 2 = bus timeout
- instr_retired  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired count

## Operation
States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. State is registered; outputs decode from state plus the internal 32-bit instruction register (IR).

- **FETCH:** imem_req=1.
  - On imem_ready: IR<=ins_code, ir_write=1, pc_write=1, pc_sel=0, then go to DECODE.
- **DECODE:** ir_write=1 (operand read).
  - Legal opcodes IR[6:2]: 01100 OP, 00100 OP-IMM, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11001 JALR, 11011 JAL, 01101 LUI, 00101 AUIPC.
  - IR[1:0]!=11, any other opcode, or BRANCH funct3 010/011: go to TRAP with cause 1.
- **EXECUTE:** ALU controls per class; next state as listed.
  - OP/OP-IMM: alu_ctrl from funct3/IR[30]. IR[30] selects SUB only for OP, and SRA for both. Next WB.
  - LOAD/STORE: alusrc=1, ADD. Next MEM.
  - LUI: a=zero, imm, ADD. AUIPC: a=old PC, imm, ADD. Both next WB.
  - JAL: a=old PC, imm, ADD, pc_write=1, pc_sel=1. JALR: a=rs1, imm, ADD, pc_write=1, pc_sel=1. Both next WB.
  - BRANCH: alu_ctrl=SUB. pc_write=1, pc_sel=1 iff the condition holds: BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu. instr_retired=1, next FETCH.
  - Branch target adder is datapath-owned.
- **MEM:** dmem_req=1, with mem_read (LOAD) or mem_write (STORE).
  - On dmem_ready: LOAD goes to WB; STORE pulses instr_retired and goes to FETCH.
- **WB:** regwrite=1 unless rd (IR[11:7]) == 0. writeback_sel: LOAD 1, JAL/JALR 2, else 0. instr_retired=1, next FETCH.
- **TRAP:** all strobes 0, trap=1, trap_cause held. Exit only via rst.
- **Counter:** instret increments on each instr_retired and wraps modulo 2^CNT_W.

## Timing
- **Reset:** while rst=1, all outputs 0, instret=0, IR=0, state<=FETCH, wait counter 0. In the first cycle after rst falls, imem_req=1.
- **Latency with zero-wait memory:**
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- **Wait counter:** counts consecutive FETCH/MEM cycles without ready and clears on state change.
  - When it reaches MEM_TIMEOUT, the next state is TRAP with cause 2.
  - If ready arrives in the same cycle the counter reaches MEM_TIMEOUT, ready wins.
- **Reset priority:** rst overrides everything, including mid-MEM, and abandons the access: dmem_req drops the next cycle.
- **Strobe rules:** ins_code is ignored outside the FETCH handshake cycle; strobes are never asserted in two states at once.

## Test plan
- **ADD:** rst 2 cycles, then ins_code 0x002081B3 (add x3,x1,x2), imem_ready=1 → FETCH→DECODE→EXECUTE (alu_ctrl=0000, alusrc=0)→WB (regwrite=1, writeback_sel=0); instr_retired in cycle 4, instret=1.
- **LW with stall:** 0x0000A183 (lw x3,0(x1)) with dmem_ready low 3 cycles → dmem_req=1, mem_read=1 held 4 cycles, then WB with writeback_sel=1; 8 cycles total.
- **Branch sweep:** BEQ/BNE/BLT/BGE/BLTU/BGEU with each flag combination → pc_write=1 exactly when the condition holds; no regwrite; 3-cycle retirement.
- **x0 write:** add x0,x1,x2 (0x00208033) → regwrite stays 0 in WB; instr_retired still pulses.
- **Illegal instruction:** 0xFFFFFFFF → TRAP after DECODE, trap=1, trap_cause=1. Further imem_ready is ignored until rst, which returns the unit to FETCH with trap=0.
- **Timeout:** MEM_TIMEOUT=4, imem_ready held low → trap_cause=2 after 4 wait cycles. Repeat with ready arriving in the 4th cycle → normal DECODE.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: latches the instruction at fetch, sequences DECODE/EXECUTE/MEM/WB.
// Latency 3-5 cycles at zero wait; stalls while imem/dmem are not ready, traps once the wait budget runs out.
module multicycle_control_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ins_code,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             alu_zero,
   input  logic             alu_lt,
   input  logic             alu_ltu,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_sel,
   output logic [1:0]       alu_a_sel,
   output logic             alusrc,
   output logic [3:0]       alu_ctrl,
   output logic             regwrite,
   output logic [1:0]       writeback_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic             instr_retired,
   output logic [CNT_W-1:0] instret
);
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_t;

   state_t              state_q, state_d;
   logic [31:0]         ir_q;
   logic [WAIT_W-1:0]   wait_q;
   logic [1:0]          cause_q, cause_d;
   logic [CNT_W-1:0]    instret_q;
   logic [4:0]          opc;
   logic [2:0]          f3;
   logic                illegal, br_taken, waiting, timeout;
   logic                unused_ir;

   assign opc       = ir_q[6:2];
   assign f3        = ir_q[14:12];
   assign unused_ir = ^{ir_q[31], ir_q[29:15]};
   assign instret   = instret_q;

   assign illegal = (ir_q[1:0] != 2'b11)
                 || !(opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                  OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC})
                 || (opc == OPC_BRANCH && f3[2:1] == 2'b01);

   always_comb begin
      case (f3)
         3'b000:  br_taken = alu_zero;
         3'b001:  br_taken = !alu_zero;
         3'b100:  br_taken = alu_lt;
         3'b101:  br_taken = !alu_lt;
         3'b110:  br_taken = alu_ltu;
         3'b111:  br_taken = !alu_ltu;
         default: br_taken = 1'b0;
      endcase
   end

   // Timeout fires in the cycle the wait count would reach MEM_TIMEOUT; a ready in that cycle wins.
   assign waiting = (state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready);
   assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   function automatic logic [3:0] alu_decode(input logic [2:0] fn, input logic bit30, input logic is_op);
      case (fn)
         3'b000:  return (is_op && bit30) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return bit30 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         cause_q   <= 2'd0;
         wait_q    <= '0;
         ir_q      <= 32'd0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (state_d != state_q)
            wait_q <= '0;
         else if (waiting && MEM_TIMEOUT != 0)
            wait_q <= wait_q + 1'b1;
         if (state_q == S_FETCH && imem_ready)
            ir_q <= ins_code;
         if (instr_retired)
            instret_q <= instret_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) state_d = S_DECODE;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = 2'd2;
            end
         end
         S_DECODE: begin
            if (illegal) begin
               state_d = S_TRAP;
               cause_d = 2'd1;
            end else state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (opc == OPC_LOAD || opc == OPC_STORE) state_d = S_MEM;
            else if (opc == OPC_BRANCH)               state_d = S_FETCH;
            else                                      state_d = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) state_d = (opc == OPC_LOAD) ? S_WB : S_FETCH;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = 2'd2;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_sel        = 1'b0;
      alu_a_sel     = 2'd0;
      alusrc        = 1'b0;
      alu_ctrl      = ALU_ADD;
      regwrite      = 1'b0;
      writeback_sel = 2'd0;
      trap          = 1'b0;
      trap_cause    = 2'd0;
      instr_retired = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
               pc_write = imem_ready;
            end
            S_DECODE: ir_write = 1'b1;
            S_EXECUTE: begin
               case (opc)
                  OPC_OP:     alu_ctrl = alu_decode(f3, ir_q[30], 1'b1);
                  OPC_OP_IMM: begin
                     alusrc   = 1'b1;
                     alu_ctrl = alu_decode(f3, ir_q[30], 1'b0);
                  end
                  OPC_LOAD, OPC_STORE: alusrc = 1'b1;
                  OPC_LUI: begin
                     alu_a_sel = 2'd2;
                     alusrc    = 1'b1;
                  end
                  OPC_AUIPC: begin
                     alu_a_sel = 2'd1;
                     alusrc    = 1'b1;
                  end
                  OPC_JAL: begin
                     alu_a_sel = 2'd1;
                     alusrc    = 1'b1;
                     pc_write  = 1'b1;
                     pc_sel    = 1'b1;
                  end
                  OPC_JALR: begin
                     alusrc   = 1'b1;
                     pc_write = 1'b1;
                     pc_sel   = 1'b1;
                  end
                  OPC_BRANCH: begin
                     alu_ctrl      = ALU_SUB;
                     pc_write      = br_taken;
                     pc_sel        = br_taken;
                     instr_retired = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               dmem_req      = 1'b1;
               mem_read      = (opc == OPC_LOAD);
               mem_write     = (opc == OPC_STORE);
               instr_retired = dmem_ready && (opc == OPC_STORE);
            end
            S_WB: begin
               regwrite      = (ir_q[11:7] != 5'd0);
               writeback_sel = (opc == OPC_LOAD) ? 2'd1 :
                               (opc == OPC_JAL || opc == OPC_JALR) ? 2'd2 : 2'd0;
               instr_retired = 1'b1;
            end
            S_TRAP: begin
               trap       = 1'b1;
               trap_cause = cause_q;
            end
            default: ;
         endcase
      end
   end
endmodule
